// File: rtl/dbg_bridge_if.sv
// dbg_bridge_if -- debug bridge bus bundle.
//   HALT  : CPU hold request from the bridge
//   BUSEN : bridge owns the bus this cycle
//   ADDR  : bus address
//   DO    : write data from the bridge
//   RW    : 1 = read, 0 = write
//   DI    : read data into the bridge (synchronous memory, one cycle after ADDR)
// master = bridge side, slave = memory/CPU side.
interface dbg_bridge_if;
  logic        HALT;
  logic        BUSEN;
  logic [15:0] ADDR;
  logic [7:0]  DO;
  logic        RW;
  logic [7:0]  DI;

  modport master (
    output HALT,
    output BUSEN,
    output ADDR,
    output DO,
    output RW,
    input  DI
  );

  modport slave (
    input  HALT,
    input  BUSEN,
    input  ADDR,
    input  DO,
    input  RW,
    output DI
  );
endinterface

// File: rtl/dbg_bridge.sv
// dbg_bridge -- serial (8N1) debug bridge that can halt the CPU and perform
// single read/write cycles on its bus.
//   CLK   : system clock
//   RESET : synchronous active-high reset
//   rxd   : serial command input, idle high
//   txd   : serial reply output, idle high
//   bus   : dbg_bridge_if.master (HALT, BUSEN, ADDR, DO, RW out; DI in)
// Commands: 'H' halt, 'G' go, 'W' hi lo data write, 'R' hi lo read,
// 'I' read at last address + 1. Replies 'K', read data, 'E' (not halted)
// or '?' (unknown command).
module dbg_bridge #(
  parameter int unsigned CLK_DIV      = 165,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         rxd,
  output logic         txd,
  dbg_bridge_if.master bus
);

  localparam int unsigned CW        = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLK_DIV;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_G = 8'h47;
  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_Q = 8'h3F;

  // Receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Parser states
  localparam logic [2:0] P_IDLE    = 3'd0;
  localparam logic [2:0] P_ADDR_HI = 3'd1;
  localparam logic [2:0] P_ADDR_LO = 3'd2;
  localparam logic [2:0] P_DATA    = 3'd3;
  localparam logic [2:0] P_BUS     = 3'd4;
  localparam logic [2:0] P_REPLY   = 3'd5;

  // ---------------------------------------------------------------- receiver
  logic          rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_valid_q, rx_valid_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // glitch: line back high at mid-start, not a real start bit
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rxd_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_valid_d = rxd_s2_q;   // framing error: byte silently dropped
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // ------------------------------------------------------ single-byte buffer
  logic       buf_valid_q, buf_valid_d;
  logic [7:0] buf_q, buf_d;
  logic       byte_take;

  always_comb begin
    buf_valid_d = buf_valid_q && !byte_take;
    buf_d       = buf_q;
    // a byte arriving while the buffer stays full is dropped
    if (rx_valid_q && (!buf_valid_q || byte_take)) begin
      buf_valid_d = 1'b1;
      buf_d       = rx_sh_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
    end
  end

  // ------------------------------------------------------------- transmitter
  logic          tx_go_q, tx_go_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_busy_q, tx_busy_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;

  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_sh_d   = tx_sh_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    if (!tx_busy_q) begin
      if (tx_go_q) begin
        tx_busy_d = 1'b1;
        tx_sh_d   = {1'b1, tx_data_q, 1'b0};
        tx_cnt_d  = '0;
        tx_bit_d  = '0;
      end
    end else if (tx_cnt_q == DIV_LAST) begin
      tx_cnt_d = '0;
      tx_sh_d  = {1'b1, tx_sh_q[9:1]};
      if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
      else                  tx_bit_d  = tx_bit_q + 1'b1;
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_busy_q <= 1'b0;
      tx_sh_q   <= '1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
    end else begin
      tx_busy_q <= tx_busy_d;
      tx_sh_q   <= tx_sh_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
    end
  end

  assign txd = tx_busy_q ? tx_sh_q[0] : 1'b1;

  // ------------------------------------------------------------------ parser
  logic [2:0]      p_state_q, p_state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      addr_hi_q, addr_hi_d;
  logic [7:0]      addr_lo_q, addr_lo_d;
  logic            halt_q, halt_d;
  logic            busen_q, busen_d;
  logic            rw_q, rw_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      do_q, do_d;
  logic            bus_cnt_q, bus_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic            do_reply, do_read, do_write;
  logic [7:0]      reply_byte;
  logic [15:0]     read_addr;

  assign byte_take = buf_valid_q &&
                     ((p_state_q == P_IDLE)    || (p_state_q == P_ADDR_HI) ||
                      (p_state_q == P_ADDR_LO) || (p_state_q == P_DATA));

  always_comb begin
    p_state_d  = p_state_q;
    cmd_d      = cmd_q;
    addr_hi_d  = addr_hi_q;
    addr_lo_d  = addr_lo_q;
    halt_d     = halt_q;
    busen_d    = busen_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    do_d       = do_q;
    bus_cnt_d  = bus_cnt_q;
    to_cnt_d   = '0;
    tx_go_d    = 1'b0;
    tx_data_d  = tx_data_q;
    do_reply   = 1'b0;
    do_read    = 1'b0;
    do_write   = 1'b0;
    reply_byte = CH_K;
    read_addr  = addr_q;

    // partial commands time out after a silent gap
    if ((p_state_q == P_ADDR_HI || p_state_q == P_ADDR_LO ||
         p_state_q == P_DATA) && !byte_take) begin
      if (to_cnt_q == TO_LAST) p_state_d = P_IDLE;
      else                     to_cnt_d  = to_cnt_q + 1'b1;
    end

    case (p_state_q)
      P_IDLE: begin
        if (byte_take) begin
          case (buf_q)
            CH_H: begin halt_d = 1'b1; do_reply = 1'b1; end
            CH_G: begin halt_d = 1'b0; do_reply = 1'b1; end
            CH_W, CH_R: begin
              cmd_d     = buf_q;
              p_state_d = P_ADDR_HI;
            end
            CH_I: begin
              if (halt_q) begin
                do_read   = 1'b1;
                read_addr = addr_q + 16'd1;
              end else begin
                do_reply   = 1'b1;
                reply_byte = CH_E;
              end
            end
            default: begin do_reply = 1'b1; reply_byte = CH_Q; end
          endcase
        end
      end
      P_ADDR_HI: begin
        if (byte_take) begin
          addr_hi_d = buf_q;
          p_state_d = P_ADDR_LO;
        end
      end
      P_ADDR_LO: begin
        if (byte_take) begin
          addr_lo_d = buf_q;
          if (cmd_q == CH_W) begin
            p_state_d = P_DATA;
          end else if (halt_q) begin
            do_read   = 1'b1;
            read_addr = {addr_hi_q, buf_q};
          end else begin
            do_reply   = 1'b1;
            reply_byte = CH_E;
          end
        end
      end
      P_DATA: begin
        if (byte_take) begin
          if (halt_q) begin
            do_write = 1'b1;
          end else begin
            do_reply   = 1'b1;
            reply_byte = CH_E;
          end
        end
      end
      P_BUS: begin
        if (!rw_q) begin
          busen_d  = 1'b0;
          rw_d     = 1'b1;
          do_reply = 1'b1;
        end else if (!bus_cnt_q) begin
          bus_cnt_d = 1'b1;
        end else begin
          // DI now reflects the address presented one cycle earlier
          busen_d    = 1'b0;
          do_reply   = 1'b1;
          reply_byte = bus.DI;
        end
      end
      P_REPLY: begin
        if (!tx_go_q && !tx_busy_q) p_state_d = P_IDLE;
      end
      default: p_state_d = P_IDLE;
    endcase

    if (do_reply) begin
      tx_go_d   = 1'b1;
      tx_data_d = reply_byte;
      p_state_d = P_REPLY;
    end
    if (do_read) begin
      busen_d   = 1'b1;
      rw_d      = 1'b1;
      addr_d    = read_addr;
      bus_cnt_d = 1'b0;
      p_state_d = P_BUS;
    end
    if (do_write) begin
      busen_d   = 1'b1;
      rw_d      = 1'b0;
      addr_d    = {addr_hi_q, addr_lo_q};
      do_d      = buf_q;
      p_state_d = P_BUS;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      p_state_q <= P_IDLE;
      cmd_q     <= '0;
      addr_hi_q <= '0;
      addr_lo_q <= '0;
      halt_q    <= 1'b0;
      busen_q   <= 1'b0;
      rw_q      <= 1'b1;
      addr_q    <= '0;
      do_q      <= '0;
      bus_cnt_q <= 1'b0;
      to_cnt_q  <= '0;
      tx_go_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      p_state_q <= p_state_d;
      cmd_q     <= cmd_d;
      addr_hi_q <= addr_hi_d;
      addr_lo_q <= addr_lo_d;
      halt_q    <= halt_d;
      busen_q   <= busen_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      do_q      <= do_d;
      bus_cnt_q <= bus_cnt_d;
      to_cnt_q  <= to_cnt_d;
      tx_go_q   <= tx_go_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.HALT  = halt_q;
  assign bus.BUSEN = busen_q;
  assign bus.RW    = rw_q;
  assign bus.ADDR  = addr_q;
  assign bus.DO    = do_q;

endmodule

// File: tb/tb_dbg_bridge.sv
module tb_dbg_bridge;
  localparam int unsigned DIV = 8;
  localparam int unsigned TOB = 20;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic rxd   = 1'b1;
  logic txd;

  dbg_bridge_if bus_if();

  dbg_bridge #(.CLK_DIV(DIV), .TIMEOUT_BITS(TOB)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .rxd   (rxd),
    .txd   (txd),
    .bus   (bus_if)
  );

  always #5 CLK = ~CLK;

  // read-only synchronous memory model
  function automatic logic [7:0] rom(input logic [15:0] a);
    case (a)
      16'h0800: return 8'hA5;
      16'h0801: return 8'hC3;
      16'hFFFF: return 8'h11;
      16'h0000: return 8'h22;
      default:  return 8'hEE;
    endcase
  endfunction

  always @(posedge CLK) bus_if.DI <= rom(bus_if.ADDR);

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b1;

  logic [7:0]  exp_reply[$];
  logic [27:0] exp_bus[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {RW after cycle, rw, length, addr, write data (0 for reads)}
  function automatic logic [27:0] bus_key(input logic rw, input int len,
                                          input logic [15:0] a, input logic [7:0] d);
    logic [1:0] l;
    l = (len > 3) ? 2'd3 : 2'(len);
    return {1'b1, rw, l, a, rw ? 8'h00 : d};
  endfunction

  // reply monitor: decodes txd and compares against the reply queue
  initial begin
    logic       prev;
    logic [7:0] b;
    logic       stp;
    prev = 1'b1;
    forever begin
      @(negedge CLK);
      if (prev && !txd) begin
        repeat (DIV/2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge CLK);
          b[i] = txd;
        end
        repeat (DIV) @(negedge CLK);
        stp = txd;
        if (mon_en) begin
          if (exp_reply.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL reply_unexpected: got %h expected none", b);
          end else begin
            check("reply", {23'd0, stp, b}, {23'd0, 1'b1, exp_reply.pop_front()});
          end
        end
      end
      prev = txd;
    end
  end

  // bus monitor: measures each BUSEN pulse and compares against the bus queue
  initial begin
    bit          in_cyc;
    int          len;
    logic        c_rw;
    logic [15:0] c_addr;
    logic [7:0]  c_do;
    logic [27:0] act;
    in_cyc = 1'b0;
    len    = 0;
    forever begin
      @(negedge CLK);
      if (bus_if.BUSEN === 1'b1) begin
        if (!in_cyc) begin
          in_cyc = 1'b1;
          len    = 1;
          c_rw   = bus_if.RW;
          c_addr = bus_if.ADDR;
          c_do   = bus_if.DO;
        end else begin
          len++;
        end
      end else if (in_cyc) begin
        in_cyc = 1'b0;
        act = bus_key(c_rw, len, c_addr, c_do);
        act[27] = bus_if.RW;
        if (exp_bus.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got %h expected none", act);
        end else begin
          check("bus_cycle", {4'd0, act}, {4'd0, exp_bus.pop_front()});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge CLK);
    rxd = 1'b0;
    repeat (DIV) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge CLK);
    end
    rxd = stop_bit;
    repeat (DIV) @(negedge CLK);
    rxd = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_reply.size() != 0 || exp_bus.size() != 0) && n < 60*DIV) begin
      @(negedge CLK);
      n++;
    end
    if (exp_reply.size() != 0 || exp_bus.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got replies=%0d bus=%0d pending expected 0",
               exp_reply.size(), exp_bus.size());
      exp_reply.delete();
      exp_bus.delete();
    end
    repeat (2*DIV) @(negedge CLK);
  endtask

  initial begin
    int n;
    // reset state
    RESET = 1'b1;
    repeat (4) @(negedge CLK);
    check("rst_txd",   {31'd0, txd},          32'd1);
    check("rst_halt",  {31'd0, bus_if.HALT},  32'd0);
    check("rst_busen", {31'd0, bus_if.BUSEN}, 32'd0);
    check("rst_rw",    {31'd0, bus_if.RW},    32'd1);
    check("rst_addr",  {16'd0, bus_if.ADDR},  32'h0000);
    check("rst_do",    {24'd0, bus_if.DO},    32'h00);
    RESET = 1'b0;
    repeat (4*DIV) @(negedge CLK);

    // halt, then write 0x5A to 0x0800
    exp_reply.push_back(8'h4B);
    send(8'h48);
    drain();
    check("halt_set", {31'd0, bus_if.HALT}, 32'd1);
    exp_bus.push_back(bus_key(1'b0, 1, 16'h0800, 8'h5A));
    exp_reply.push_back(8'h4B);
    send(8'h57); send(8'h08); send(8'h00); send(8'h5A);
    drain();
    check("do_hold", {24'd0, bus_if.DO}, 32'h5A);

    // read 0x0800, then increment-read 0x0801
    exp_bus.push_back(bus_key(1'b1, 2, 16'h0800, 8'h00));
    exp_reply.push_back(8'hA5);
    send(8'h52); send(8'h08); send(8'h00);
    drain();
    exp_bus.push_back(bus_key(1'b1, 2, 16'h0801, 8'h00));
    exp_reply.push_back(8'hC3);
    send(8'h49);
    drain();
    check("addr_hold", {16'd0, bus_if.ADDR}, 32'h0801);

    // unknown command, framing-error byte, address wrap on 'I'
    exp_reply.push_back(8'h3F);
    send(8'h00);
    drain();
    send_byte(8'h48, 1'b0);
    repeat (4*DIV) @(negedge CLK);
    exp_bus.push_back(bus_key(1'b1, 2, 16'hFFFF, 8'h00));
    exp_reply.push_back(8'h11);
    send(8'h52); send(8'hFF); send(8'hFF);
    drain();
    exp_bus.push_back(bus_key(1'b1, 2, 16'h0000, 8'h00));
    exp_reply.push_back(8'h22);
    send(8'h49);
    drain();

    // partial command abandoned after a long gap, then 'G'
    send(8'h52); send(8'h12);
    repeat (25*DIV) @(negedge CLK);
    exp_reply.push_back(8'h4B);
    send(8'h47);
    drain();
    check("halt_clr", {31'd0, bus_if.HALT}, 32'd0);

    // bus commands while not halted
    exp_reply.push_back(8'h45);
    send(8'h57); send(8'h00); send(8'h10); send(8'h77);
    drain();
    exp_reply.push_back(8'h45);
    send(8'h49);
    drain();
    check("addr_no_e", {16'd0, bus_if.ADDR}, 32'h0000);

    // reset in the middle of the 'K' reply
    mon_en = 1'b0;
    send(8'h48);
    n = 0;
    while (txd === 1'b1 && n < 20*DIV) begin
      @(negedge CLK);
      n++;
    end
    check("reply_started", {31'd0, txd}, 32'd0);
    repeat (3*DIV) @(negedge CLK);
    check("halt_before_rst", {31'd0, bus_if.HALT}, 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_txd",  {31'd0, txd},         32'd1);
    check("abort_halt", {31'd0, bus_if.HALT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (12*DIV) @(negedge CLK);
    check("post_rst_txd", {31'd0, txd}, 32'd1);
    mon_en = 1'b1;
    exp_reply.push_back(8'h4B);
    send(8'h48);
    drain();
    check("halt_after_rst", {31'd0, bus_if.HALT}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
